// File: rtl/frame_reg_pkg.sv
// rtl/frame_reg_pkg.sv - field map, default command addresses and access decode type for frame_reg_bank
package frame_reg_pkg;

  localparam int DEL1_BASE   = 0;
  localparam int DUR1_BASE   = 4;
  localparam int THHV_ADDR   = 8;
  localparam int RES_ADDR    = 9;
  localparam int N_ACTIVE    = 10;
  localparam int FIELD_BYTES = 4;

  localparam int DEF_COMMIT_ADDR = 15;
  localparam int DEF_STATUS_ADDR = 14;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_SHADOW,
    ACC_STATUS,
    ACC_COMMIT
  } acc_kind_e;

endpackage

// File: rtl/cs_edge_detect.sv
// rtl/cs_edge_detect.sv - cs_n falling-edge pulse; 2-flop synchronizer in front when FRAME_REG_BUS_SYNC_EN is defined
module cs_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  output logic fall
);

`ifdef FRAME_REG_BUS_SYNC_EN
  // [0],[1] synchronize cs_n; [2] holds the previous synchronized level
  logic [2:0] cs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q <= 3'b111;
    end else begin
      cs_q <= {cs_q[1:0], cs_n};
    end
  end

  assign fall = cs_q[2] & ~cs_q[1];
`else
  logic cs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q <= 1'b1;
    end else begin
      cs_q <= cs_n;
    end
  end

  assign fall = cs_q & ~cs_n;
`endif

endmodule

// File: rtl/frame_reg_bank.sv
// rtl/frame_reg_bank.sv - shadow/active register bank with frame-gated atomic commit
// FRAME_REG_BUS_SYNC_EN selects a synchronized cs_n path in cs_edge_detect
module frame_reg_bank
  import frame_reg_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 8,
  parameter int COMMIT_ADDR = DEF_COMMIT_ADDR,
  parameter int STATUS_ADDR = DEF_STATUS_ADDR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs_n,
  input  logic                          rw,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          frame_active,
  output logic [DATA_W-1:0]             data_out,
  output logic                          rd_valid,
  output logic [FIELD_BYTES*DATA_W-1:0] del1,
  output logic [FIELD_BYTES*DATA_W-1:0] dur1,
  output logic [DATA_W-1:0]             thhv,
  output logic [DATA_W-1:0]             res_value,
  output logic                          commit_pending
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] COMMIT_A = ADDR_W'(COMMIT_ADDR);
  localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(STATUS_ADDR);

  logic              access;
  acc_kind_e         kind;
  logic [IDX_W-1:0]  idx;
  logic              do_copy;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] shadow   [DEPTH];
  logic [DATA_W-1:0] act_bank [N_ACTIVE];

  cs_edge_detect u_cs_edge (
    .clk  (clk),
    .rst  (rst),
    .cs_n (cs_n),
    .fall (access)
  );

  assign idx     = addr[IDX_W-1:0];
  assign do_copy = commit_pending & ~frame_active;

  // Command addresses take precedence over the plain shadow range
  always_comb begin
    kind = ACC_NONE;
    if (addr == COMMIT_A) begin
      kind = ACC_COMMIT;
    end else if (addr == STATUS_A) begin
      kind = ACC_STATUS;
    end else if (32'(addr) < 32'(DEPTH)) begin
      kind = ACC_SHADOW;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (kind)
      ACC_SHADOW: rd_mux = shadow[idx];
      ACC_STATUS: rd_mux = {{(DATA_W-1){1'b0}}, commit_pending};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow[i] <= '0;
      end
    end else if (access && rw && (kind == ACC_SHADOW)) begin
      shadow[idx] <= data_in;
    end
  end

  // A commit request arriving while one is already pending is absorbed
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pending <= 1'b0;
    end else if (do_copy) begin
      commit_pending <= 1'b0;
    end else if (access && rw && (kind == ACC_COMMIT) && data_in[0]) begin
      commit_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ACTIVE; i++) begin
        act_bank[i] <= '0;
      end
    end else if (do_copy) begin
      for (int i = 0; i < N_ACTIVE; i++) begin
        act_bank[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      data_out <= '0;
    end else begin
      rd_valid <= access & ~rw;
      if (access && !rw) begin
        data_out <= rd_mux;
      end
    end
  end

  // Lowest address of each multi-byte field is its most significant byte
  always_comb begin
    del1 = '0;
    dur1 = '0;
    for (int i = 0; i < FIELD_BYTES; i++) begin
      del1[(FIELD_BYTES-1-i)*DATA_W +: DATA_W] = act_bank[DEL1_BASE+i];
      dur1[(FIELD_BYTES-1-i)*DATA_W +: DATA_W] = act_bank[DUR1_BASE+i];
    end
  end

  assign thhv      = act_bank[THHV_ADDR];
  assign res_value = act_bank[RES_ADDR];

endmodule
